serv_hart_dbgctl: RTL and testbench
===================================

// Module: serv_hart_dbgctl
// PURPOSE
//  Multi-hart debug halt/resume controller for SERV cores with the debug extension.
//  Converts debug-module requests (haltreq, resumereq) for a selected hart into
//  i_debug_interrupt pulses, and tracks per-hart run state from each core's
//  debug-entry (o_debug_we) and dret-retire strobes.
//  Sits between the debug transport (DMI) and NUM_HARTS serv_top instances.
// PARAMETERS
//  NUM_HARTS    1    number of controlled harts (1..32)
//  HARTSEL_W    5    width of i_hartsel; indices >= NUM_HARTS select no hart
//  TIMEOUT_W    8    width of the per-hart halt-pending timeout counter
//  HALT_TIMEOUT 255  cycles in HALT_PEND before abandoning the request (< 2**TIMEOUT_W)
// PORTS
//  clk             in   1          clock
//  i_rst           in   1          synchronous active-high reset
//  i_hartsel       in   HARTSEL_W  selected hart index
//  i_haltreq       in   1          level: request halt of the selected hart
//  i_resumereq     in   1          pulse: request resume of the selected hart
//  i_debug_enter   in   NUM_HARTS  per-hart 1-cycle strobe: hart entered debug mode (serv o_debug_we)
//  i_debug_exit    in   NUM_HARTS  per-hart 1-cycle strobe: hart retired dret
//  o_debug_irq     out  NUM_HARTS  per-hart debug interrupt to serv i_debug_interrupt
//  o_resume_go     out  NUM_HARTS  per-hart 1-cycle go flag to the debug ROM loop
//  o_halted        out  NUM_HARTS  per-hart halted status (state HALTED)
//  o_sel_halted    out  1          selected hart is HALTED
//  o_sel_running   out  1          selected hart is RUNNING
//  o_sel_resumeack out  1          sticky resume-ack of the selected hart
//  o_sel_timeout   out  1          sticky halt-timeout of the selected hart
//  o_sel_nonexist  out  1          i_hartsel >= NUM_HARTS
//  o_anyhalted     out  1          OR of o_halted (macro-dependent, see CONFIGURATION)
//  o_allhalted     out  1          AND of o_halted (macro-dependent)
// BEHAVIOUR
//  - Per-hart FSM: RUNNING(00), HALT_PEND(01), HALTED(10), RESUME_PEND(11); sel = (i_hartsel==h).
//  - Reset: all harts RUNNING; every output 0; resumeack and timeout flags 0; counters 0.
//  - RUNNING: sel & i_haltreq -> HALT_PEND (counter cleared).
//      i_debug_enter (e.g. ebreak) -> HALTED directly.
//  - HALT_PEND: o_debug_irq[h]=1 (registered; asserted the cycle after entry).
//      i_debug_enter -> HALTED; irq drops the same edge.
//      !(sel & i_haltreq) -> RUNNING.
//      counter == HALT_TIMEOUT -> RUNNING, timeout flag set.
//      Otherwise the counter increments.
//      Priority: enter > withdraw > timeout.
//  - HALTED: sel & i_resumereq & !i_haltreq -> RESUME_PEND.
//      Same edge: o_resume_go[h]=1 for exactly 1 cycle; resumeack cleared.
//      A resumereq while haltreq is high is ignored (halt has precedence).
//  - RESUME_PEND: i_debug_exit -> RUNNING, resumeack set. Further resumereq are ignored.
//  - A new sel & i_haltreq in RUNNING clears the timeout flag of that hart.
//  - i_debug_exit outside RESUME_PEND: hart -> RUNNING; resumeack is not set.
//  - i_debug_enter in RESUME_PEND or HALTED: stays/goes HALTED.
//  - o_sel_*: combinational muxes of the registered per-hart state.
//      All are 0 except o_sel_nonexist when the selected index does not exist.
//  - i_rst mid-operation: every FSM returns to RUNNING next edge; pending irq/go dropped.
//  - Harts are independent. Only the selected hart reacts to requests.
//      Strobes from any hart are honoured every cycle.
// CONFIGURATION
//  - SERV_DBG_HALTSUM_EN defined: o_anyhalted/o_allhalted are registered summaries of
//    the next-state halted vector, coherent with o_halted in the same cycle.
//  - Undefined: both outputs are tied 0 and no summary logic is built.
// TESTING
//  - Reset, NUM_HARTS=4: all o_* = 0; o_sel_running=1 for hartsel=0.
//  - hartsel=2, haltreq=1 -> debug_irq[2]=1 next cycle; debug_enter[2] 3 cycles later
//    -> o_halted=4'b0100, irq[2]=0.
//  - Hart 2 halted, haltreq=0, resumereq pulse -> resume_go[2] 1 cycle;
//    debug_exit[2] -> sel_running=1, sel_resumeack=1.
//  - HALT_TIMEOUT=10, haltreq held, no enter -> irq[1] drops after 11 cycles; sel_timeout=1.
//  - debug_enter[0] (ebreak) while RUNNING, no request -> o_halted[0]=1;
//    with the macro, anyhalted=1 and allhalted=0.
//  - hartsel=7 with NUM_HARTS=4, haltreq=1 -> sel_nonexist=1, no irq. Then i_rst mid
//    HALT_PEND -> all RUNNING, irq=0.

Source files
------------

// File: rtl/serv_hart_dbgctl.sv
// serv_hart_dbgctl: multi-hart debug halt/resume controller for SERV cores.
// Turns DM halt/resume requests for the selected hart into debug interrupt
// pulses and tracks each hart's run state from its debug-entry/dret strobes.
// Optional feature: define SERV_DBG_HALTSUM_EN to build the registered
// anyhalted/allhalted summaries; otherwise both outputs are tied low.
module serv_hart_dbgctl #(
    parameter int NUM_HARTS    = 1,
    parameter int HARTSEL_W    = 5,
    parameter int TIMEOUT_W    = 8,
    parameter int HALT_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic [HARTSEL_W-1:0] i_hartsel,
    input  logic                 i_haltreq,
    input  logic                 i_resumereq,
    input  logic [NUM_HARTS-1:0] i_debug_enter,
    input  logic [NUM_HARTS-1:0] i_debug_exit,
    output logic [NUM_HARTS-1:0] o_debug_irq,
    output logic [NUM_HARTS-1:0] o_resume_go,
    output logic [NUM_HARTS-1:0] o_halted,
    output logic                 o_sel_halted,
    output logic                 o_sel_running,
    output logic                 o_sel_resumeack,
    output logic                 o_sel_timeout,
    output logic                 o_sel_nonexist,
    output logic                 o_anyhalted,
    output logic                 o_allhalted
);

    typedef enum logic [1:0] {
        RUNNING     = 2'b00,
        HALT_PEND   = 2'b01,
        HALTED      = 2'b10,
        RESUME_PEND = 2'b11
    } state_t;

    logic [NUM_HARTS-1:0] run_v;
    logic [NUM_HARTS-1:0] ack_v;
    logic [NUM_HARTS-1:0] to_v;
`ifdef SERV_DBG_HALTSUM_EN
    logic [NUM_HARTS-1:0] halted_nxt;
`endif

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        state_t               state_q, state_d;
        logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
        logic                 ack_q, ack_d;
        logic                 to_q, to_d;
        logic                 go_d;
        logic                 irq_q, go_q, halted_q;
        logic                 hreq;

        assign hreq = (i_hartsel == HARTSEL_W'(h)) && i_haltreq;

        // Next-state logic: debug entry wins over everything, then dret retire,
        // then request withdrawal, then the halt-pending timeout.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            ack_d   = ack_q;
            to_d    = to_q;
            go_d    = 1'b0;
            if (hreq && state_q == RUNNING)
                to_d = 1'b0;
            if (i_debug_enter[h]) begin
                state_d = HALTED;
            end else begin
                unique case (state_q)
                    RUNNING: begin
                        if (hreq) begin
                            state_d = HALT_PEND;
                            cnt_d   = '0;
                        end
                    end
                    HALT_PEND: begin
                        if (i_debug_exit[h] || !hreq) begin
                            state_d = RUNNING;
                        end else if (cnt_q == TIMEOUT_W'(HALT_TIMEOUT)) begin
                            state_d = RUNNING;
                            to_d    = 1'b1;
                        end else begin
                            cnt_d = cnt_q + TIMEOUT_W'(1);
                        end
                    end
                    HALTED: begin
                        if (i_debug_exit[h]) begin
                            state_d = RUNNING;
                        end else if ((i_hartsel == HARTSEL_W'(h)) && i_resumereq && !i_haltreq) begin
                            state_d = RESUME_PEND;
                            go_d    = 1'b1;
                            ack_d   = 1'b0;
                        end
                    end
                    RESUME_PEND: begin
                        if (i_debug_exit[h]) begin
                            state_d = RUNNING;
                            ack_d   = 1'b1;
                        end
                    end
                    default: state_d = RUNNING;
                endcase
            end
        end

        // State and registered per-hart outputs, decoded from the next state
        always_ff @(posedge clk) begin
            if (i_rst) begin
                state_q  <= RUNNING;
                cnt_q    <= '0;
                ack_q    <= 1'b0;
                to_q     <= 1'b0;
                irq_q    <= 1'b0;
                go_q     <= 1'b0;
                halted_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                ack_q    <= ack_d;
                to_q     <= to_d;
                irq_q    <= (state_d == HALT_PEND);
                go_q     <= go_d;
                halted_q <= (state_d == HALTED);
            end
        end

        assign o_debug_irq[h] = irq_q;
        assign o_resume_go[h] = go_q;
        assign o_halted[h]    = halted_q;
        assign run_v[h]       = (state_q == RUNNING);
        assign ack_v[h]       = ack_q;
        assign to_v[h]        = to_q;
`ifdef SERV_DBG_HALTSUM_EN
        assign halted_nxt[h]  = (state_d == HALTED);
`endif
    end

    // Selected-hart status muxes; a nonexistent index reads as all zero
    always_comb begin
        o_sel_halted    = 1'b0;
        o_sel_running   = 1'b0;
        o_sel_resumeack = 1'b0;
        o_sel_timeout   = 1'b0;
        o_sel_nonexist  = 1'b1;
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            if (i_hartsel == HARTSEL_W'(h)) begin
                o_sel_nonexist  = 1'b0;
                o_sel_halted    = o_halted[h];
                o_sel_running   = run_v[h];
                o_sel_resumeack = ack_v[h];
                o_sel_timeout   = to_v[h];
            end
        end
    end

`ifdef SERV_DBG_HALTSUM_EN
    // Summaries register the next-state vector so they line up with o_halted
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_anyhalted <= 1'b0;
            o_allhalted <= 1'b0;
        end else begin
            o_anyhalted <= |halted_nxt;
            o_allhalted <= &halted_nxt;
        end
    end
`else
    assign o_anyhalted = 1'b0;
    assign o_allhalted = 1'b0;
`endif

endmodule

// File: tb/tb_serv_hart_dbgctl.sv
// Bench for serv_hart_dbgctl (NUM_HARTS=4, HALT_TIMEOUT=10): a directed vector
// table, a hand-written timeout sequence, then random traffic against a model.
module tb_serv_hart_dbgctl;

    localparam int NH = 4;
    localparam int TO = 10;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [4:0]    i_hartsel = '0;
    logic          i_haltreq = 1'b0;
    logic          i_resumereq = 1'b0;
    logic [NH-1:0] i_debug_enter = '0;
    logic [NH-1:0] i_debug_exit = '0;
    logic [NH-1:0] o_debug_irq, o_resume_go, o_halted;
    logic          o_sel_halted, o_sel_running, o_sel_resumeack, o_sel_timeout;
    logic          o_sel_nonexist, o_anyhalted, o_allhalted;

    int total = 0;
    int bad = 0;

    serv_hart_dbgctl #(
        .NUM_HARTS(NH), .HARTSEL_W(5), .TIMEOUT_W(8), .HALT_TIMEOUT(TO)
    ) dut (
        .clk(clk), .i_rst(i_rst), .i_hartsel(i_hartsel), .i_haltreq(i_haltreq),
        .i_resumereq(i_resumereq), .i_debug_enter(i_debug_enter),
        .i_debug_exit(i_debug_exit), .o_debug_irq(o_debug_irq),
        .o_resume_go(o_resume_go), .o_halted(o_halted),
        .o_sel_halted(o_sel_halted), .o_sel_running(o_sel_running),
        .o_sel_resumeack(o_sel_resumeack), .o_sel_timeout(o_sel_timeout),
        .o_sel_nonexist(o_sel_nonexist), .o_anyhalted(o_anyhalted),
        .o_allhalted(o_allhalted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [4:0]    hs;
        logic          hq, rq;
        logic [NH-1:0] en, ex;
        logic [NH-1:0] irq, halt, go;
        logic          sh, sr, sa, st, sn;
    } vec_t;

    vec_t vec[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [NH-1:0] irq, input logic [NH-1:0] halt,
                             input logic [NH-1:0] go, input logic sh, input logic sr,
                             input logic sa, input logic st, input logic sn);
        logic any_e, all_e;
`ifdef SERV_DBG_HALTSUM_EN
        any_e = |halt;
        all_e = &halt;
`else
        any_e = 1'b0;
        all_e = 1'b0;
`endif
        chk({tag, ".irq"}, 32'(o_debug_irq), 32'(irq));
        chk({tag, ".halted"}, 32'(o_halted), 32'(halt));
        chk({tag, ".go"}, 32'(o_resume_go), 32'(go));
        chk({tag, ".sel"}, {27'b0, o_sel_halted, o_sel_running, o_sel_resumeack, o_sel_timeout, o_sel_nonexist},
            {27'b0, sh, sr, sa, st, sn});
        chk({tag, ".summary"}, {30'b0, o_anyhalted, o_allhalted}, {30'b0, any_e, all_e});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: per-hart status letter, remaining pending budget, sticky flags
    byte m_mode[NH];   // "R" running, "P" halt requested, "H" halted, "G" resume issued
    int  m_budget[NH];
    bit  m_ack[NH], m_tout[NH], m_go[NH];

    task automatic model_reset();
        for (int h = 0; h < NH; h++) begin
            m_mode[h] = "R"; m_budget[h] = 0; m_ack[h] = 0; m_tout[h] = 0; m_go[h] = 0;
        end
    endtask

    task automatic model_step();
        for (int h = 0; h < NH; h++) begin
            bit sel = (int'(i_hartsel) == h);
            bit want = sel && i_haltreq;
            m_go[h] = 0;
            if (want && m_mode[h] == "R") m_tout[h] = 0;
            if (i_debug_enter[h]) m_mode[h] = "H";
            else if (m_mode[h] == "R") begin
                if (want) begin m_mode[h] = "P"; m_budget[h] = TO + 1; end
            end else if (m_mode[h] == "P") begin
                if (i_debug_exit[h] || !want) m_mode[h] = "R";
                else begin
                    m_budget[h]--;
                    if (m_budget[h] == 0) begin m_mode[h] = "R"; m_tout[h] = 1; end
                end
            end else if (m_mode[h] == "H") begin
                if (i_debug_exit[h]) m_mode[h] = "R";
                else if (sel && i_resumereq && !i_haltreq) begin
                    m_mode[h] = "G"; m_go[h] = 1; m_ack[h] = 0;
                end
            end else begin
                if (i_debug_exit[h]) begin m_mode[h] = "R"; m_ack[h] = 1; end
            end
        end
    endtask

    task automatic model_check(input string tag);
        logic [NH-1:0] irq, halt, go;
        logic sh, sr, sa, st, sn;
        int s = int'(i_hartsel);
        for (int h = 0; h < NH; h++) begin
            irq[h] = (m_mode[h] == "P");
            halt[h] = (m_mode[h] == "H");
            go[h] = m_go[h];
        end
        sn = (s >= NH);
        sh = !sn && m_mode[s % NH] == "H";
        sr = !sn && m_mode[s % NH] == "R";
        sa = !sn && m_ack[s % NH];
        st = !sn && m_tout[s % NH];
        check_all(tag, irq, halt, go, sh, sr, sa, st, sn);
    endtask

    initial begin
        //          rst hs  hq rq en       ex       irq      halt     go       sh sr sa st sn
        vec[0]  = '{1, 5'd0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 0, 0};
        vec[1]  = '{0, 5'd2, 1, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0, 0, 0};
        vec[2]  = '{0, 5'd2, 1, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0, 0, 0};
        vec[3]  = '{0, 5'd2, 1, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0, 0, 0};
        vec[4]  = '{0, 5'd2, 1, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1, 0, 0, 0, 0};
        vec[5]  = '{0, 5'd2, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 0, 0, 0, 0, 0};
        vec[6]  = '{0, 5'd2, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0};
        vec[7]  = '{0, 5'd2, 0, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1, 0, 0};
        vec[8]  = '{0, 5'd0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0, 0, 0};
        vec[9]  = '{0, 5'd7, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0, 0, 1};
        vec[10] = '{0, 5'd1, 1, 0, 4'b0000, 4'b0000, 4'b0010, 4'b0001, 4'b0000, 0, 0, 0, 0, 0};
        vec[11] = '{0, 5'd1, 1, 0, 4'b0000, 4'b0000, 4'b0010, 4'b0001, 4'b0000, 0, 0, 0, 0, 0};
        vec[12] = '{1, 5'd1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 0, 0};
        vec[13] = '{0, 5'd3, 0, 0, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1, 0, 0, 0, 0};
        vec[14] = '{0, 5'd3, 1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1, 0, 0, 0, 0};
        vec[15] = '{0, 5'd3, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0, 0, 0, 0, 0};
        vec[16] = '{0, 5'd3, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0};
        vec[17] = '{0, 5'd3, 0, 0, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1, 0, 0, 0, 0};
        vec[18] = '{0, 5'd3, 0, 0, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 0, 0};

        for (int i = 0; i < 19; i++) begin
            i_rst = vec[i].rst; i_hartsel = vec[i].hs; i_haltreq = vec[i].hq;
            i_resumereq = vec[i].rq; i_debug_enter = vec[i].en; i_debug_exit = vec[i].ex;
            tick();
            check_all($sformatf("vec%0d", i), vec[i].irq, vec[i].halt, vec[i].go,
                      vec[i].sh, vec[i].sr, vec[i].sa, vec[i].st, vec[i].sn);
        end

        // Halt request on hart 1 never answered: irq held for TO+1 cycles, then timeout
        i_rst = 0; i_hartsel = 5'd1; i_haltreq = 1; i_resumereq = 0;
        i_debug_enter = '0; i_debug_exit = '0;
        tick();
        check_all("to_entry", 4'b0010, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        for (int i = 1; i <= TO; i++) begin
            tick();
            check_all($sformatf("to_hold%0d", i), 4'b0010, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        end
        tick();
        check_all("to_expire", 4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 1, 0);
        tick();
        check_all("to_rearm", 4'b0010, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        i_haltreq = 0;
        tick();
        check_all("to_withdraw", 4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 0, 0);

        // Random traffic against the model
        i_rst = 1;
        tick();
        model_reset();
        model_check("rnd_reset");
        i_rst = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [NH-1:0] en, ex;
            i_rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) == 0) i_hartsel = 5'($urandom_range(0, 5));
            if ($urandom_range(0, 11) == 0) i_haltreq = ~i_haltreq;
            i_resumereq = ($urandom_range(0, 3) == 0);
            for (int h = 0; h < NH; h++) begin
                en[h] = ($urandom_range(0, 24) == 0);
                ex[h] = ($urandom_range(0, 15) == 0) && !en[h];
            end
            i_debug_enter = en;
            i_debug_exit = ex;
            tick();
            if (i_rst) model_reset();
            else model_step();
            model_check($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
